// File: rtl/out_hs_buffer_if.sv
// Link-side bundle of out_hs_buffer: FIFO read side, ro/so downstream handshake, occupancy.
// The stall line exists only when OUT_HS_STALL_DET_EN is defined.
interface out_hs_buffer_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 2
);
    logic              empty;
    logic [DATA_W-1:0] in_packet;
    logic              read_en;
    logic              ro;
    logic              so;
    logic [DATA_W-1:0] out_packet;
    logic [CNT_W-1:0]  occupancy;
`ifdef OUT_HS_STALL_DET_EN
    logic              stall;
`endif

    // Buffer side: consumes the FIFO head and drives the link.
    modport master (
        input  empty, in_packet, ro,
`ifdef OUT_HS_STALL_DET_EN
        output stall,
`endif
        output read_en, so, out_packet, occupancy
    );

    // Environment side: the FIFO and the downstream link.
    modport slave (
        output empty, in_packet, ro,
`ifdef OUT_HS_STALL_DET_EN
        input  stall,
`endif
        input  read_en, so, out_packet, occupancy
    );
endinterface

// File: rtl/out_hs_buffer.sv
// Output handshake buffer: DEPTH-entry prefetch queue between a show-ahead FIFO and the ro/so link.
// Latency: 1 cycle pop-to-send; 1 pkt/cycle when DEPTH>=2. Backpressure: ro=0 holds head, full buffer stops popping.
// Optional stall watchdog compiled in with OUT_HS_STALL_DET_EN.
module out_hs_buffer #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 2,
    parameter int CNT_W       = $clog2(DEPTH + 1),
    parameter int STALL_LIMIT = 255
) (
    input  logic           clk,
    input  logic           reset,
    out_hs_buffer_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              read_en;
    logic              so;

    // No pass-through: a full buffer never pops, even when sending this cycle.
    assign read_en = reset & ~bus.empty & (count_q < FULL);
    assign so      = reset & (count_q != '0) & bus.ro;

    assign bus.read_en    = read_en;
    assign bus.so         = so;
    assign bus.out_packet = mem_q[rd_ptr_q];
    assign bus.occupancy  = count_q;

    // Power-of-two depth lets the pointer wrap by overflow; a single entry never moves.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1) return '0;
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (read_en) begin
            mem_d[wr_ptr_q] = bus.in_packet;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (so) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (read_en && !so) begin
            count_d = count_q + CNT_W'(1);
        end else if (so && !read_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef OUT_HS_STALL_DET_EN
    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    localparam logic [SC_W-1:0] LIMIT = SC_W'(STALL_LIMIT);

    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            stall_q, stall_d;

    // Counter saturates at LIMIT; the flag is sticky until the head finally leaves.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;
        if (so || (count_q == '0)) begin
            stall_cnt_d = '0;
        end else if (!bus.ro && (stall_cnt_q != LIMIT)) begin
            stall_cnt_d = stall_cnt_q + SC_W'(1);
        end
        if (so) begin
            stall_d = 1'b0;
        end else if (stall_cnt_d == LIMIT) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.stall = stall_q;
`endif
endmodule
